delay_tap_reader: RTL and testbench

DELAY_TAP_READER -- requirements
Module: delay_tap_reader

---
 rtl/delay_tap_reader_if.sv | 15 +
 rtl/delay_tap_reader.sv | 140 ++++++++++++++
 tb/tb_delay_tap_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_tap_reader_if.sv
// delay_tap_reader_if: read port between the tap reader and the delay-line sample memory.
//   rd_req  : reader -> memory, read request
//   rd_addr : reader -> memory, read address (valid while rd_req=1)
//   rd_ack  : memory -> reader, request accepted, rd_data valid this cycle
//   rd_data : memory -> reader, signed 16-bit sample
interface delay_tap_reader_if #(
  parameter int AW = 11
);
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic               rd_ack;
  logic signed [15:0] rd_data;
  modport master (output rd_req, rd_addr, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: reads NUM_TAPS spaced delay-line taps per sample strobe and outputs their floored mean.
//   clk, rst_n     : clock, asynchronous active-low reset
//   sample_strobe  : new sample written at wr_ptr (one-cycle pulse)
//   wr_ptr         : address of the newest sample
//   mem            : sample memory read port (master side)
//   audio_out      : registered mixed output, holds between out_valid pulses
//   out_valid      : one-cycle pulse when audio_out updates
//   busy           : high while a tap read sequence is in progress
//   overrun        : one-cycle pulse when a strobe is dropped
//   timeout        : only with TAPREAD_TIMEOUT_EN; pulses when a read is aborted after 16 unacked cycles
module delay_tap_reader #(
  parameter int AW          = 11,
  parameter int NUM_TAPS    = 4,
  parameter int TAP_SPACING = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic [AW-1:0]       wr_ptr,
  delay_tap_reader_if.master  mem,
  output logic signed [15:0]  audio_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
`ifdef TAPREAD_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);
  localparam int L = $clog2(NUM_TAPS);
  localparam int AC = 16 + L;
  localparam logic [AW-1:0] STEP = AW'(TAP_SPACING);
  typedef enum logic {IDLE, READ} state_t;
  state_t               state_q, state_d;
  logic [L-1:0]         k_q, k_d;
  logic signed [AC-1:0] acc_q, acc_d, sum;
  logic                 rd_req_q, rd_req_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic signed [15:0]   audio_q, audio_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 last;
`ifdef TAPREAD_TIMEOUT_EN
  logic [3:0]           wait_q, wait_d;
  logic                 timeout_q, timeout_d;
`endif
  assign last = k_q == L'(NUM_TAPS - 1);
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    audio_d     = audio_q;
    out_valid_d = 1'b0;
    overrun_d   = 1'b0;
    sum         = acc_q + {{L{mem.rd_data[15]}}, mem.rd_data};
`ifdef TAPREAD_TIMEOUT_EN
    wait_d      = wait_q;
    timeout_d   = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (sample_strobe) begin
        state_d   = READ;
        k_d       = '0;
        acc_d     = '0;
        rd_req_d  = 1'b1;
        rd_addr_d = wr_ptr;
`ifdef TAPREAD_TIMEOUT_EN
        wait_d    = '0;
`endif
      end
    end else begin
      // Any strobe seen outside IDLE, including the last-ack cycle, is dropped.
      overrun_d = sample_strobe;
      if (mem.rd_ack) begin
        acc_d     = sum;
        k_d       = k_q + L'(1);
        rd_addr_d = rd_addr_q - STEP;
`ifdef TAPREAD_TIMEOUT_EN
        wait_d    = '0;
`endif
        if (last) begin
          state_d     = IDLE;
          rd_req_d    = 1'b0;
          audio_d     = 16'(sum >>> L);
          out_valid_d = 1'b1;
        end
      end
`ifdef TAPREAD_TIMEOUT_EN
      else if (wait_q == 4'd15) begin
        state_d   = IDLE;
        rd_req_d  = 1'b0;
        timeout_d = 1'b1;
        wait_d    = '0;
      end else begin
        wait_d = wait_q + 4'd1;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      audio_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef TAPREAD_TIMEOUT_EN
      wait_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      audio_q     <= audio_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef TAPREAD_TIMEOUT_EN
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
`endif
    end
  end
  assign mem.rd_req  = rd_req_q;
  assign mem.rd_addr = rd_addr_q;
  assign audio_out   = audio_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign busy        = state_q != IDLE;
`ifdef TAPREAD_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif
endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: scoreboard bench with a behavioural memory and tap-mean model.
module tb_delay_tap_reader;
  localparam int AW = 11;
  localparam int NT = 4;
  localparam int SP = 256;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_strobe = 1'b0;
  logic [AW-1:0] wr_ptr = '0;
  logic signed [15:0] audio_out;
  logic out_valid, busy, overrun, tmo_w;
  logic signed [15:0] mem_arr [DEPTH];
  int ack_mode = 1;
  int zeros = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_ovr = 0;
  int exp_ovr = 0;
  int addr_q [$];
  int exp_q [$];
  int held = 0;
  bit prev_stall = 0;
  int prev_addr = 0;
  delay_tap_reader_if #(.AW(AW)) mem_if ();
  delay_tap_reader #(.AW(AW), .NUM_TAPS(NT), .TAP_SPACING(SP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_strobe(sample_strobe),
    .wr_ptr(wr_ptr),
    .mem(mem_if.master),
    .audio_out(audio_out),
    .out_valid(out_valid),
    .busy(busy),
    .overrun(overrun)
`ifdef TAPREAD_TIMEOUT_EN
    ,
    .timeout(tmo_w)
`endif
  );
`ifndef TAPREAD_TIMEOUT_EN
  assign tmo_w = 1'b0;
`endif
  always #5 clk = ~clk;
  assign mem_if.rd_data = mem_arr[mem_if.rd_addr];
  // ack_mode: 0 never ack, 1 always ack, 2 random with at most 3 consecutive stalls
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) mem_if.rd_ack = 1'b0;
    else if (ack_mode == 1) mem_if.rd_ack = 1'b1;
    else begin
      mem_if.rd_ack = (zeros >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      zeros = mem_if.rd_ack ? 0 : zeros + 1;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int tap_addr(input int base, input int k);
    return ((base - k * SP) % DEPTH + DEPTH) % DEPTH;
  endfunction
  // Floored mean of the taps, computed with integer division.
  function automatic int model_out(input int base);
    int s = 0;
    for (int k = 0; k < NT; k++) s += int'(mem_arr[tap_addr(base, k)]);
    return (s - ((s % NT) + NT) % NT) / NT;
  endfunction
  task automatic issue(input int p, input bit expect_out);
    @(negedge clk);
    sample_strobe = 1'b1;
    wr_ptr = AW'(p);
    if (expect_out) begin
      for (int k = 0; k < NT; k++) addr_q.push_back(tap_addr(p, k));
      exp_q.push_back(model_out(p));
    end
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask
  task automatic set_taps(input int p, input int v0, input int v1, input int v2, input int v3);
    mem_arr[tap_addr(p, 0)] = 16'(v0);
    mem_arr[tap_addr(p, 1)] = 16'(v1);
    mem_arr[tap_addr(p, 2)] = 16'(v2);
    mem_arr[tap_addr(p, 3)] = 16'(v3);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      held = 0;
    end else begin
      if (prev_stall && !tmo_w) begin
        chk("stall_rd_req", int'(mem_if.rd_req), 1);
        chk("stall_rd_addr", int'(mem_if.rd_addr), prev_addr);
      end
      if (mem_if.rd_req && mem_if.rd_ack) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_read: unexpected read at addr %0d", mem_if.rd_addr);
        end else chk("rd_addr", int'(mem_if.rd_addr), addr_q.pop_front());
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_out_valid: audio_out %0d with nothing expected", audio_out);
        end else chk("audio_out", int'(audio_out), exp_q.pop_front());
        held = int'(audio_out);
      end else chk("audio_hold", int'(audio_out), held);
      if (overrun) n_ovr++;
      prev_stall = mem_if.rd_req && !mem_if.rd_ack;
      prev_addr = int'(mem_if.rd_addr);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 16'($urandom);
    mem_if.rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", int'(mem_if.rd_req), 0);
    chk("rst_rd_addr", int'(mem_if.rd_addr), 0);
    chk("rst_audio_out", int'(audio_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Wrap-around base with ack tied high also measures strobe-to-out_valid latency.
    issue(100, 1);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, NT + 1);
    wait_idle();
    set_taps(500, 1000, 2000, -3000, 4);
    issue(500, 1);
    wait_idle();
    set_taps(1000, -1, -1, -1, -2);
    issue(1000, 1);
    wait_idle();
    set_taps(2000, 32767, 32767, 32767, 32767);
    issue(2000, 1);
    wait_idle();
    set_taps(50, -32768, -32768, -32768, -32768);
    issue(50, 1);
    wait_idle();
    set_taps(700, -32768, 32767, -32768, -1);
    issue(700, 1);
    wait_idle();
    // Strobe two cycles after an accepted strobe is dropped.
    issue(300, 1);
    @(negedge clk);
    sample_strobe = 1'b1;
    wr_ptr = AW'(900);
    @(negedge clk);
    sample_strobe = 1'b0;
    chk("overrun_pulse", int'(overrun), 1);
    exp_ovr++;
    @(negedge clk);
    chk("overrun_single", int'(overrun), 0);
    wait_idle();
    // Strobe coinciding with the last tap ack is dropped as well.
    issue(1500, 1);
    repeat (3) @(negedge clk);
    sample_strobe = 1'b1;
    wr_ptr = AW'(1200);
    @(negedge clk);
    sample_strobe = 1'b0;
    chk("overrun_last_ack", int'(overrun), 1);
    exp_ovr++;
    @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    ack_mode = 2;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wait_idle();
      issue(int'($urandom_range(0, DEPTH - 1)), 1);
    end
    wait_idle();
    // Reset in the middle of a read sequence.
    ack_mode = 0;
    repeat (2) @(negedge clk);
    issue(1800, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd_req", int'(mem_if.rd_req), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_audio_out", int'(audio_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 2;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    issue(1800, 1);
    wait_idle();
`ifdef TAPREAD_TIMEOUT_EN
    ack_mode = 0;
    repeat (2) @(negedge clk);
    issue(1234, 0);
    cyc = 1;
    while (!tmo_w && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_latency", cyc - 1, 16);
    chk("timeout_busy", int'(busy), 0);
    @(negedge clk);
    chk("timeout_single", int'(tmo_w), 0);
    ack_mode = 1;
    repeat (2) @(negedge clk);
    issue(77, 1);
    wait_idle();
`endif
    repeat (5) @(negedge clk);
    chk("pending_outputs", exp_q.size(), 0);
    chk("pending_reads", addr_q.size(), 0);
    chk("overrun_count", n_ovr, exp_ovr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
